// File: rtl/wave_capture_ctrl.sv
// Zero-crossing triggered 256-sample capture into the idle half of a 512x8 RAM.
// Define WAVE_CAPTURE_TIMEOUT_EN to force a trigger after TIMEOUT_SAMPLES idle samples.
module wave_capture_ctrl #(
  parameter int TIMEOUT_SAMPLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_sample_ready,
  input  logic [15:0] new_sample_in,
  input  logic        chip_vsync,
  output logic [8:0]  write_address,
  output logic [7:0]  write_sample,
  output logic        write_enable,
  output logic        read_index,
  output logic [1:0]  capture_state
);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] count;
  logic       prev_msb;
  logic       vsync_q;
  logic       force_trig;
  logic       crossing;
  logic       vsync_fall;
  logic [7:0] conv;

  assign conv       = new_sample_in[15:8] ^ 8'h80;
  assign crossing   = prev_msb & ~new_sample_in[15];
  assign vsync_fall = vsync_q & ~chip_vsync;

`ifdef WAVE_CAPTURE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_SAMPLES + 1);
  logic [TW-1:0] tmo;

  assign force_trig = (tmo == TW'(TIMEOUT_SAMPLES));
`else
  // Timeout disabled: the comparison is constant false.
  assign force_trig = (TIMEOUT_SAMPLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ARMED;
      count         <= 8'h00;
      prev_msb      <= 1'b0;
      vsync_q       <= 1'b1;
      write_enable  <= 1'b0;
      write_address <= 9'h000;
      write_sample  <= 8'h00;
      read_index    <= 1'b0;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
      tmo           <= '0;
`endif
    end else begin
      vsync_q      <= chip_vsync;
      write_enable <= 1'b0;
      if (new_sample_ready)
        prev_msb <= new_sample_in[15];
      case (state)
        ARMED: begin
          if (new_sample_ready) begin
            if (crossing || force_trig) begin
              write_enable  <= 1'b1;
              write_address <= {~read_index, 8'h00};
              write_sample  <= conv;
              count         <= 8'h01;
              state         <= ACTIVE;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
              tmo           <= '0;
            end else begin
              tmo <= tmo + TW'(1);
`endif
            end
          end
        end
        ACTIVE: begin
          if (new_sample_ready) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, count};
            write_sample  <= conv;
            count         <= count + 8'h01;
            if (count == 8'hFF)
              state <= WAIT;
          end
        end
        WAIT: begin
          // Swap only at frame boundary so the display never tears.
          if (vsync_fall) begin
            read_index <= ~read_index;
            state      <= ARMED;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
            tmo        <= '0;
`endif
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

  assign capture_state = state;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Bench for wave_capture_ctrl: vector table, directed corner sequences,
// and randomized traffic against a buffer-level reference model.
module tb_wave_capture_ctrl;

  localparam int TIMEOUT = 1024;
`ifdef WAVE_CAPTURE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        chip_vsync;
  logic [8:0]  write_address;
  logic [7:0]  write_sample;
  logic        write_enable;
  logic        read_index;
  logic [1:0]  capture_state;

  wave_capture_ctrl #(.TIMEOUT_SAMPLES(TIMEOUT)) dut (
    .clk              (clk),
    .reset            (reset),
    .new_sample_ready (new_sample_ready),
    .new_sample_in    (new_sample_in),
    .chip_vsync       (chip_vsync),
    .write_address    (write_address),
    .write_sample     (write_sample),
    .write_enable     (write_enable),
    .read_index       (read_index),
    .capture_state    (capture_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wr_seen = 0;

  // Model: fill = -1 waiting for trigger, 0..255 samples stored, 256 full.
  int         m_fill;
  bit         m_idx;
  bit         m_prev;
  bit         m_vq;
  int         m_tmo;
  bit         m_we;
  logic [8:0] m_addr;
  logic [7:0] m_data;

  typedef struct {
    bit          rst;
    bit          rdy;
    logic [15:0] s;
    bit          vs;
    logic [20:0] exp;
  } vec_t;

  function automatic logic [20:0] pack(bit we, logic [8:0] a,
                                       logic [7:0] d, bit ri,
                                       logic [1:0] st);
    return {we, a, d, ri, st};
  endfunction

  function automatic logic [20:0] dut_out();
    return {write_enable, write_address, write_sample,
            read_index, capture_state};
  endfunction

  function automatic logic [20:0] model_out();
    logic [1:0] st;
    st = (m_fill < 0) ? 2'd0 : (m_fill == 256) ? 2'd2 : 2'd1;
    return {m_we, m_addr, m_data, m_idx, st};
  endfunction

  task automatic check(input string name, input logic [20:0] got,
                       input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit rdy,
                            input logic [15:0] s, input bit vs);
    bit fall;
    bit start;
    if (rst) begin
      m_fill = -1; m_idx = 0; m_prev = 0; m_vq = 1; m_tmo = 0;
      m_we = 0; m_addr = '0; m_data = '0;
      return;
    end
    fall = m_vq && !vs;
    m_vq = vs;
    m_we = 0;
    if (m_fill == 256) begin
      if (fall) begin
        m_idx = !m_idx; m_fill = -1; m_tmo = 0;
      end
    end else if (rdy) begin
      start = (m_fill < 0) &&
              ((m_prev && !s[15]) || (TMO_EN && m_tmo == TIMEOUT));
      if (m_fill < 0 && !start) m_tmo++;
      if (start) begin
        m_fill = 0; m_tmo = 0;
      end
      if (m_fill >= 0) begin
        m_we   = 1;
        m_addr = {~m_idx, 8'(m_fill)};
        m_data = 8'((int'(s[15:8]) + 128) % 256);
        m_fill++;
      end
    end
    if (rdy) m_prev = s[15];
  endtask

  task automatic step(input bit rst, input bit rdy,
                      input logic [15:0] s, input bit vs);
    reset = rst; new_sample_ready = rdy;
    new_sample_in = s; chip_vsync = vs;
    model_step(rst, rdy, s, vs);
    @(posedge clk);
    #1;
    if (write_enable === 1'b1) wr_seen++;
    check("model", dut_out(), model_out());
  endtask

  vec_t vt[7];
  int   w0;
  int   first;
  bit   vs_r;

  initial begin
    reset = 1; new_sample_ready = 0; new_sample_in = '0; chip_vsync = 1;
    vt[0] = '{1, 0, 16'h0000, 1, pack(0, 9'h000, 8'h00, 0, 2'd0)};
    vt[1] = '{0, 1, 16'h8000, 1, pack(0, 9'h000, 8'h00, 0, 2'd0)};
    vt[2] = '{0, 1, 16'h1234, 1, pack(1, 9'h100, 8'h92, 0, 2'd1)};
    vt[3] = '{0, 0, 16'h5555, 1, pack(0, 9'h100, 8'h92, 0, 2'd1)};
    vt[4] = '{0, 1, 16'h0000, 1, pack(1, 9'h101, 8'h80, 0, 2'd1)};
    vt[5] = '{0, 1, 16'h7FFF, 1, pack(1, 9'h102, 8'hFF, 0, 2'd1)};
    vt[6] = '{0, 1, 16'h8000, 1, pack(1, 9'h103, 8'h00, 0, 2'd1)};
    for (int i = 0; i < 7; i++) begin
      step(vt[i].rst, vt[i].rdy, vt[i].s, vt[i].vs);
      check($sformatf("vec%0d", i), dut_out(), vt[i].exp);
    end

    // Finish the ramp: 252 more writes, then strobes in WAIT.
    w0 = wr_seen;
    for (int i = 4; i < 256; i++) step(0, 1, 16'(i * 128), 1);
    check("ramp_writes", 21'(wr_seen - w0), 21'd252);
    check("ramp_last", {12'h0, write_address}, {12'h0, 9'h1FF});
    w0 = wr_seen;
    for (int i = 0; i < 10; i++) step(0, 1, 16'h8000 ^ 16'(i), 1);
    check("wait_nowrite", 21'(wr_seen - w0), 21'd0);
    check("wait_state", {19'h0, capture_state}, 21'd2);

    // Frame swap, then capture into the lower region.
    step(0, 0, 16'h0, 0);
    check("swap_ri", {20'h0, read_index}, 21'd1);
    step(0, 1, 16'hFF00, 0);
    w0 = wr_seen;
    for (int i = 0; i < 256; i++) step(0, 1, 16'(i), 0);
    check("low_writes", 21'(wr_seen - w0), 21'd256);
    check("low_last", {12'h0, write_address}, {12'h0, 9'h0FF});

    // Falling edge coincident with the final write is not a swap.
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 0);
    step(0, 1, 16'h8000, 1);
    for (int i = 0; i < 255; i++) step(0, 1, 16'(i), 1);
    step(0, 1, 16'h0042, 0);
    check("coinc_state", {19'h0, capture_state}, 21'd2);
    for (int i = 0; i < 5; i++) step(0, 0, 16'h0, 0);
    check("coinc_noswap", {20'h0, read_index}, 21'd0);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 0);
    check("coinc_swap", {20'h0, read_index}, 21'd1);

    // Reset mid-capture abandons the buffer.
    step(0, 1, 16'h8000, 1);
    for (int i = 0; i < 100; i++) step(0, 1, 16'(i), 1);
    step(1, 0, 16'h0, 1);
    check("rst_mid", dut_out(), 21'd0);
    step(0, 1, 16'h8000, 1);
    step(0, 1, 16'h0001, 1);
    check("rst_restart", dut_out(), pack(1, 9'h100, 8'h80, 0, 2'd1));

    // DC input: only the timeout can trigger.
    step(1, 0, 16'h0, 1);
    w0 = wr_seen;
    first = -1;
    for (int i = 1; i <= 2000; i++) begin
      step(0, 1, 16'h0100, 1);
      if (write_enable === 1'b1 && first < 0) first = i;
    end
    check("dc_writes", 21'(wr_seen - w0), TMO_EN ? 21'd256 : 21'd0);
    check("dc_first", 21'(first + 1), TMO_EN ? 21'(TIMEOUT + 2) : 21'd0);

    // Randomized traffic.
    step(1, 0, 16'h0, 1);
    vs_r = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) vs_r = !vs_r;
      step($urandom_range(0, 1499) == 0, $urandom_range(0, 9) < 7,
           16'($urandom), vs_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_capture_ctrl.md
# wave_capture_ctrl

Write-side sequencer for the 512-entry, 8-bit dual-region sample RAM that `wave_display` reads through `read_index`/`read_address`. It waits for a positive-going zero crossing in the incoming 16-bit audio stream and writes 256 consecutive samples, converted to offset binary, into the region the display is not reading. It then holds until the next falling edge of `chip_vsync` and flips `read_index`, so a buffer swap never lands mid-frame.

## Interface
Parameters:
- `TIMEOUT_SAMPLES`, 1024: accepted-sample count in ARMED before a forced trigger (used only with `WAVE_CAPTURE_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `new_sample_ready`  in  1  one-cycle strobe; `new_sample_in` is valid this cycle.
- `new_sample_in`  in  16  signed two's-complement audio sample.
- `chip_vsync`  in  1  active-low vertical sync from the DVI controller.
- `write_address`  out  9  RAM write address, `{~read_index, count[7:0]}`.
- `write_sample`  out  8  RAM write data.
- `write_enable`  out  1  RAM write strobe.
- `read_index`  out  1  region currently owned by `wave_display`.
- `capture_state`  out  2  debug: 0 ARMED, 1 ACTIVE, 2 WAIT.

## Operation
- Sample conversion: `write_sample = new_sample_in[15:8] ^ 8'h80`, which equals the high byte + 128 mod 256 (0x8000 maps to 0x00, 0x0000 maps to 0x80, 0x7FFF maps to 0xFF).
- `prev_msb` is updated with `new_sample_in[15]` on every accepted sample in every state.
- ARMED: a trigger occurs when `new_sample_ready` is high, `prev_msb == 1`, and `new_sample_in[15] == 0`.
  - The triggering sample is written at `count = 0`, `count` becomes 1, and the state moves to ACTIVE.
  - Non-triggering samples are not written.
- ACTIVE: each accepted sample is written at the current `count`, then `count` increments.
  - The write at `count == 255` moves the state to WAIT and wraps `count` to 0.
- WAIT: samples are ignored and `write_enable` stays 0.
  - On a `chip_vsync` falling edge (`vsync_q == 1 && chip_vsync == 0`), `read_index` toggles and the state moves to ARMED.
- The write region is always `~read_index`, so the display region is never written.
- Illegal state encoding (3): return to ARMED next cycle.

## Timing
- All outputs are registered.
  - `write_enable`, `write_address` and `write_sample` are valid in the cycle after the accepting `new_sample_ready`.
  - `write_enable` is high for exactly one cycle per written sample.
- Reset values:
  - outputs: `write_enable` 0, `write_address` 9'h000, `write_sample` 8'h00, `read_index` 0, `capture_state` 0 (ARMED);
  - internal: `count` 0, `prev_msb` 0, `vsync_q` 1, timeout counter 0.
- Because `prev_msb` resets to 0, the first sample after reset cannot trigger.
- Swap latency: `read_index` changes in the cycle after the `chip_vsync` falling edge is sampled.
- A falling edge detected in the same cycle as the final ACTIVE write is not counted; the swap waits for the next frame.
- A `new_sample_ready` in the same cycle as the WAIT-to-ARMED transition is evaluated under WAIT rules (ignored), but it still updates `prev_msb`.
- Reset mid-capture: the partial buffer is abandoned and `read_index` returns to 0. Downstream must tolerate stale RAM contents.
- Back-to-back strobes are accepted every cycle with no bubbles.

## Configuration
- `WAVE_CAPTURE_TIMEOUT_EN` defined: a counter tracks accepted samples in ARMED (cleared on entry to ARMED and on reset).
  - When the count reaches `TIMEOUT_SAMPLES` without a zero-crossing trigger, the next accepted sample triggers unconditionally.
  - This keeps the display updating for DC or silent input.
- Undefined: no counter and no forced trigger. With a non-crossing input the block stays in ARMED indefinitely and `read_index` never toggles.

## Test plan
- Reset, then one sample 0x8000 followed by 0x1234: trigger, `write_address` 9'h100, `write_sample` 0x92, `write_enable` one cycle later, `capture_state` 1.
- 256-sample ramp starting at the crossing: addresses 9'h100 to 9'h1FF written in order, then `capture_state` 2 with no further writes while strobes continue.
- In WAIT, drive a `chip_vsync` falling edge: `read_index` goes 0 to 1 one cycle later; the next capture writes 9'h000 to 9'h0FF.
- Vsync falling edge coincident with the 256th strobe: no swap; swap occurs only on the following falling edge.
- Assert `reset` after 100 samples in ACTIVE: all outputs return to reset values the next cycle; the next capture restarts at address 9'h100.
- Constant 0x0100 input for 2000 samples: no writes without `WAVE_CAPTURE_TIMEOUT_EN`; with it, a forced trigger fires on accepted sample 1025 (`TIMEOUT_SAMPLES` = 1024) and 256 writes of 0x81 follow.
